wb_daq_channel_scheduler: RTL and testbench
===========================================

Name: wb_daq_channel_scheduler

Overview:
- Sequences sample transfers from the four DAQ channels onto the single DAQ Wishbone bus master.
- Latches each channel's sample-ready pulse and its data word, then arbitrates round-robin between pending channels.
- Generates the per-channel write address from a base address plus a wrapping ring pointer, and issues one write per grant.
- Sits between the channel blocks and control registers on one side and the bus master's start/done handshake on the other.

Parameters:
NUM_CHANNELS, 4, number of requesting channels (select width fixed at 2; max 4)
dw, 32, sample data width
aw, 32, bus address width
BUF_WORDS_LOG2, 8, log2 of ring length per channel in 32-bit words

Ports:
wb_clk  in  1  clock; single clock domain
wb_rst  in  1  reset, synchronous, active-high
enable  in  NUM_CHANNELS  per-channel enable (control register bits)
base_addr  in  NUM_CHANNELS*aw  channel n base address at [n*aw +: aw]
request  in  NUM_CHANNELS  one-cycle sample-ready pulse per channel
channel_data  in  NUM_CHANNELS*dw  channel n sample at [n*dw +: dw], valid in the request cycle
master_start  out  1  one-cycle pulse: bus master begins a write
master_address  out  aw  write address, held from ISSUE until done/error
master_data  out  dw  write data, held alongside master_address
master_done  in  1  bus master completed the write (ack)
master_error  in  1  bus master terminated the write with err
grant  out  NUM_CHANNELS  one-hot owner of the current transfer; 0 in IDLE
select  out  2  binary index of granted channel
busy  out  1  high in ISSUE and WAIT
overrun  out  NUM_CHANNELS  sticky: a request arrived while the previous sample was still pending
bus_error  out  NUM_CHANNELS  sticky: a transfer for this channel got master_error
wrap  out  NUM_CHANNELS  one-cycle pulse when a channel's pointer wraps to 0

Behaviour:
- Reset: all outputs 0, pending/held data/pointers 0, last_grant = NUM_CHANNELS-1, state IDLE.
- Capture: request[n] && enable[n] sets pending[n] and loads hold[n] <= channel_data[n] at that edge. Requests with enable[n]=0 are ignored.
- Overrun: if request[n] arrives while pending[n]=1 and is not being cleared in that cycle, set overrun[n] and overwrite hold[n] (newest sample wins).
- Simultaneous request and completion on the same channel: pending stays 1, new data is loaded, no overrun.
- FSM states are IDLE, ISSUE, WAIT.
- IDLE: if any pending, pick the channel (round-robin search from last_grant+1) and register grant, select, master_address and master_data. Then go to ISSUE.
- Address calculation: master_address = base_addr[n] + {ptr[n], 2'b00}, modulo 2^aw.
- ISSUE: master_start=1 for exactly one cycle, then go to WAIT.
- WAIT on master_done:
  - clear pending[n];
  - ptr[n] <= ptr[n]+1;
  - if ptr[n] was 2^BUF_WORDS_LOG2-1, set ptr[n]=0 and pulse wrap[n] for one cycle;
  - set last_grant=n and return to IDLE.
- WAIT on master_error: clear pending[n], set bus_error[n], leave ptr unchanged, set last_grant=n, return to IDLE.
- master_done and master_error together: treat as error.
- Latency: request at edge N gives master_start high in cycle N+2. Minimum 3 cycles per transfer when done arrives the cycle after start.
- enable[n] low:
  - clears pending[n], overrun[n], bus_error[n] and ptr[n] to 0;
  - an in-flight transfer for n completes the handshake but does not advance ptr or pulse wrap.
- master_done or master_error outside WAIT is ignored.
- wb_rst mid-transfer returns to IDLE immediately. The bus master is reset by the same wb_rst.

Optional Feature:
- Macro: DAQ_SCHED_FIXED_PRIORITY_EN.
- Defined: fixed priority, lowest channel index wins; last_grant is unused.
- Undefined (default): round-robin as described in Behaviour.

Test Plan:
- enable=4'h1, base_addr0=32'h1000, request[0] pulse with data 32'hA5 → master_start in cycle N+2, address 32'h1000, data 32'hA5, grant=4'b0001. After done, next request goes to 32'h1004.
- enable=4'hF, all four requests in the same cycle, done one cycle after each start → grants in order 0,1,2,3, one transfer per channel, no overrun.
- BUF_WORDS_LOG2=2, 4 completed ch1 transfers from base 32'h2000 → addresses 2000/2004/2008/200C, wrap[1] pulses on the 4th done, 5th address is 32'h2000.
- ch2 request, then a second request with data 32'h77 before grant → overrun[2]=1, a single transfer carries 32'h77. enable[2]=0 then clears overrun[2].
- master_error on a ch3 transfer → bus_error[3]=1, ptr unchanged, next ch3 write reuses the same address.
- Reset asserted in WAIT → next cycle busy=0, grant=0, pending and pointers 0. A later done pulse is ignored.

Source files
------------

// File: rtl/wb_daq_channel_scheduler_if.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | wb_daq_channel_scheduler_if                                               |
// | Start/done write handshake between the channel scheduler and bus master.  |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
interface wb_daq_channel_scheduler_if #(
  parameter int aw = 32,
  parameter int dw = 32
);
  logic          master_start;
  logic [aw-1:0] master_address;
  logic [dw-1:0] master_data;
  logic          master_done;
  logic          master_error;

  modport master (
    output master_start, master_address, master_data,
    input  master_done, master_error
  );

  modport slave (
    input  master_start, master_address, master_data,
    output master_done, master_error
  );
endinterface
`default_nettype wire

// File: rtl/wb_daq_channel_scheduler.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | wb_daq_channel_scheduler                                                  |
// | Latches channel samples, arbitrates (round-robin, or fixed priority when  |
// | DAQ_SCHED_FIXED_PRIORITY_EN is defined) and issues one ring write each.   |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module wb_daq_channel_scheduler #(
  parameter int NUM_CHANNELS   = 4,
  parameter int dw             = 32,
  parameter int aw             = 32,
  parameter int BUF_WORDS_LOG2 = 8
) (
  input  logic                       wb_clk,
  input  logic                       wb_rst,
  input  logic [NUM_CHANNELS-1:0]    enable,
  input  logic [NUM_CHANNELS*aw-1:0] base_addr,
  input  logic [NUM_CHANNELS-1:0]    request,
  input  logic [NUM_CHANNELS*dw-1:0] channel_data,
  wb_daq_channel_scheduler_if.master bus,
  output logic [NUM_CHANNELS-1:0]    grant,
  output logic [1:0]                 select,
  output logic                       busy,
  output logic [NUM_CHANNELS-1:0]    overrun,
  output logic [NUM_CHANNELS-1:0]    bus_error,
  output logic [NUM_CHANNELS-1:0]    wrap
);

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_issue = 2'd1;
  localparam logic [1:0] c_st_wait  = 2'd2;

  logic [1:0]                r_state;
  logic [NUM_CHANNELS-1:0]   r_pending;
  logic [dw-1:0]             r_hold [NUM_CHANNELS];
  logic [BUF_WORDS_LOG2-1:0] r_ptr  [NUM_CHANNELS];
  logic [1:0]                r_last_grant;

  logic [NUM_CHANNELS-1:0]   w_cap;
  logic [NUM_CHANNELS-1:0]   w_clr;
  logic                      w_done;
  logic                      w_err;
  logic                      w_found;
  logic [1:0]                w_pick;
  logic [1:0]                w_idx;
  logic [aw-1:0]             w_addr;

  // Error wins over a simultaneous done.
  assign w_err  = (r_state == c_st_wait) && bus.master_error;
  assign w_done = (r_state == c_st_wait) && bus.master_done && !bus.master_error;
  assign w_clr  = (w_done || w_err) ? grant : '0;
  assign w_cap  = request & enable;

  assign busy             = (r_state != c_st_idle);
  assign bus.master_start = (r_state == c_st_issue);

  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_idx   = '0;
`ifdef DAQ_SCHED_FIXED_PRIORITY_EN
    for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
      w_idx = 2'(i);
      if (r_pending[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
    end
`else
    for (int i = 1; i <= NUM_CHANNELS; i++) begin
      w_idx = 2'((int'(r_last_grant) + i) % NUM_CHANNELS);
      if (!w_found && r_pending[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
    end
`endif
  end

  assign w_addr = base_addr[w_pick*aw +: aw] + aw'({r_ptr[w_pick], 2'b00});

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      r_state            <= c_st_idle;
      r_pending          <= '0;
      r_last_grant       <= 2'(NUM_CHANNELS - 1);
      grant              <= '0;
      select             <= '0;
      overrun            <= '0;
      bus_error          <= '0;
      wrap               <= '0;
      bus.master_address <= '0;
      bus.master_data    <= '0;
      for (int n = 0; n < NUM_CHANNELS; n++) begin
        r_hold[n] <= '0;
        r_ptr[n]  <= '0;
      end
    end else begin
      wrap      <= '0;
      // A request landing on the completion edge keeps the channel pending.
      r_pending <= ((r_pending & ~w_clr) | w_cap) & enable;
      overrun   <= (overrun | (w_cap & r_pending & ~w_clr)) & enable;
      bus_error <= (bus_error | (w_err ? grant : '0)) & enable;

      for (int n = 0; n < NUM_CHANNELS; n++) begin
        if (w_cap[n]) begin
          r_hold[n] <= channel_data[n*dw +: dw];
        end
        if (!enable[n]) begin
          r_ptr[n] <= '0;
        end else if (w_done && grant[n]) begin
          r_ptr[n] <= r_ptr[n] + 1'b1;
          if (&r_ptr[n]) begin
            wrap[n] <= 1'b1;
          end
        end
      end

      case (r_state)
        c_st_idle: begin
          if (w_found) begin
            grant              <= NUM_CHANNELS'(1) << w_pick;
            select             <= w_pick;
            bus.master_address <= w_addr;
            bus.master_data    <= r_hold[w_pick];
            r_state            <= c_st_issue;
          end
        end
        c_st_issue: begin
          r_state <= c_st_wait;
        end
        c_st_wait: begin
          if (w_done || w_err) begin
            r_last_grant <= select;
            grant        <= '0;
            select       <= '0;
            r_state      <= c_st_idle;
          end
        end
        default: begin
          r_state <= c_st_idle;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_daq_channel_scheduler.sv
`default_nettype none
// Bench for wb_daq_channel_scheduler: scoreboard of expected writes popped on
// every master_start, plus per-scenario checks of status outputs.
module tb_wb_daq_channel_scheduler;
  localparam int NCH = 4;
  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int BWL = 2;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [NCH-1:0]     enable = '0;
  logic [NCH-1:0]     request = '0;
  logic [NCH*AW-1:0]  base_addr;
  logic [NCH*DW-1:0]  channel_data = '0;
  logic [NCH-1:0]     grant, overrun, bus_error, wrap;
  logic [1:0]         select;
  logic               busy;

  logic rsp_done = 1'b0, rsp_err = 1'b0, man_done = 1'b0;
  logic resp_err_mode = 1'b0, resp_hold = 1'b0, resp_fire = 1'b0;

  wb_daq_channel_scheduler_if #(.aw(AW), .dw(DW)) bus_if ();
  assign bus_if.master_done  = rsp_done | man_done;
  assign bus_if.master_error = rsp_err;

  wb_daq_channel_scheduler #(
    .NUM_CHANNELS(NCH), .dw(DW), .aw(AW), .BUF_WORDS_LOG2(BWL)
  ) dut (
    .wb_clk(clk), .wb_rst(rst), .enable(enable), .base_addr(base_addr),
    .request(request), .channel_data(channel_data), .bus(bus_if),
    .grant(grant), .select(select), .busy(busy), .overrun(overrun),
    .bus_error(bus_error), .wrap(wrap)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0]  addr;
    logic [DW-1:0]  data;
    logic [NCH-1:0] grant;
    logic [1:0]     sel;
  } exp_t;

  exp_t           exp_q[$];
  exp_t           e;
  int             checks = 0;
  int             errors = 0;
  int             exp_ptr[NCH];
  int             wrap_cnt = 0;
  logic [NCH-1:0] last_wrap = '0;

  function automatic void exp_push(int ch, logic [DW-1:0] d, bit adv);
    exp_t x;
    x.addr  = AW'(32'h1000 * (ch + 1)) + AW'(exp_ptr[ch] * 4);
    x.data  = d;
    x.grant = NCH'(1) << ch;
    x.sel   = 2'(ch);
    exp_q.push_back(x);
    if (adv) exp_ptr[ch] = (exp_ptr[ch] + 1) % (1 << BWL);
  endfunction

  // Bus responder and scoreboard monitor; done/err arrives the cycle after start.
  always @(negedge clk) begin
    if (wrap != '0) begin
      wrap_cnt++;
      last_wrap = wrap;
    end
    rsp_done = 1'b0;
    rsp_err  = 1'b0;
    if (resp_fire) begin
      if (resp_err_mode) rsp_err = 1'b1;
      else               rsp_done = 1'b1;
      resp_fire = 1'b0;
    end
    if (bus_if.master_start) begin
      if (!resp_hold) resp_fire = 1'b1;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL start_unexpected addr=%h data=%h", bus_if.master_address, bus_if.master_data);
      end else begin
        e = exp_q.pop_front();
        checks++;
        if (bus_if.master_address !== e.addr) begin
          errors++;
          $display("FAIL address got %h want %h", bus_if.master_address, e.addr);
        end
        checks++;
        if (bus_if.master_data !== e.data) begin
          errors++;
          $display("FAIL data got %h want %h", bus_if.master_data, e.data);
        end
        checks++;
        if (grant !== e.grant || select !== e.sel) begin
          errors++;
          $display("FAIL grant got %b/%0d want %b/%0d", grant, select, e.grant, e.sel);
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    request = '0;
    enable = '0;
    resp_err_mode = 1'b0;
    resp_hold = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NCH; i++) exp_ptr[i] = 0;
    exp_q.delete();
    wrap_cnt = 0;
    last_wrap = '0;
  endtask

  task automatic pulse(int ch, logic [DW-1:0] d);
    request[ch] = 1'b1;
    channel_data[ch*DW +: DW] = d;
    @(negedge clk);
    request[ch] = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    int quiet = 0;
    while (quiet < 4 && n < 200) begin
      @(negedge clk);
      n++;
      if (exp_q.size() == 0 && !busy) quiet++;
      else quiet = 0;
    end
    checks++;
    if (quiet < 4) begin
      errors++;
      $display("FAIL drain_timeout pending=%0d busy=%b want 0/0", exp_q.size(), busy);
    end
  endtask

  task automatic wait_start();
    int n = 0;
    while (!bus_if.master_start && n < 30) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!bus_if.master_start) begin
      errors++;
      $display("FAIL start_timeout got 0 want 1");
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (busy !== 1'b0 || grant !== '0 || select !== 2'd0) begin
      errors++;
      $display("FAIL reset_ctrl busy=%b grant=%b select=%0d want 0", busy, grant, select);
    end
    checks++;
    if (overrun !== '0 || bus_error !== '0 || wrap !== '0) begin
      errors++;
      $display("FAIL reset_status ovr=%b err=%b wrap=%b want 0", overrun, bus_error, wrap);
    end
    checks++;
    if (bus_if.master_start !== 1'b0 || bus_if.master_address !== '0 || bus_if.master_data !== '0) begin
      errors++;
      $display("FAIL reset_bus start=%b addr=%h data=%h want 0", bus_if.master_start,
               bus_if.master_address, bus_if.master_data);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    enable = 4'hF;
    for (int i = 0; i < NCH; i++) begin
      channel_data[i*DW +: DW] = DW'(32'h10 + i);
      exp_push(i, DW'(32'h10 + i), 1'b1);
    end
    request = 4'hF;
    @(negedge clk);
    request = '0;
    drain();
    checks++;
    if (overrun !== '0) begin
      errors++;
      $display("FAIL rr_overrun got %b want 0000", overrun);
    end
  endtask

  task automatic test_single();
    do_reset();
    enable = 4'h1;
    exp_push(0, 32'hA5, 1'b1);
    pulse(0, 32'hA5);
    checks++;
    if (bus_if.master_start !== 1'b0) begin
      errors++;
      $display("FAIL latency_early start got %b want 0", bus_if.master_start);
    end
    @(negedge clk);
    checks++;
    if (bus_if.master_start !== 1'b1 || busy !== 1'b1 || grant !== 4'b0001) begin
      errors++;
      $display("FAIL latency start=%b busy=%b grant=%b want 1/1/0001", bus_if.master_start, busy, grant);
    end
    drain();
    exp_push(0, 32'h5A, 1'b1);
    pulse(0, 32'h5A);
    drain();
  endtask

  task automatic test_wrap();
    do_reset();
    enable = 4'h2;
    for (int k = 0; k < 5; k++) begin
      exp_push(1, DW'(32'h200 + k), 1'b1);
      pulse(1, DW'(32'h200 + k));
      drain();
      checks++;
      if (wrap_cnt != (k >= 3 ? 1 : 0)) begin
        errors++;
        $display("FAIL wrap_count xfer %0d got %0d want %0d", k, wrap_cnt, (k >= 3 ? 1 : 0));
      end
    end
    checks++;
    if (last_wrap !== 4'b0010) begin
      errors++;
      $display("FAIL wrap_chan got %b want 0010", last_wrap);
    end
  endtask

  task automatic test_overrun();
    do_reset();
    enable = 4'b0101;
    exp_push(0, 32'hC0, 1'b1);
    exp_push(2, 32'h77, 1'b1);
    pulse(0, 32'hC0);
    pulse(2, 32'h11);
    pulse(2, 32'h77);
    drain();
    checks++;
    if (overrun !== 4'b0100) begin
      errors++;
      $display("FAIL overrun_set got %b want 0100", overrun);
    end
    enable = 4'b0001;
    @(negedge clk);
    enable = 4'b0101;
    checks++;
    if (overrun !== 4'b0000) begin
      errors++;
      $display("FAIL overrun_clear got %b want 0000", overrun);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    enable = 4'h1;
    exp_push(0, 32'hB1, 1'b1);
    exp_push(0, 32'hB2, 1'b1);
    pulse(0, 32'hB1);
    wait_start();
    @(negedge clk);
    pulse(0, 32'hB2);
    drain();
    checks++;
    if (overrun !== '0) begin
      errors++;
      $display("FAIL simul_overrun got %b want 0000", overrun);
    end
  endtask

  task automatic test_error();
    do_reset();
    enable = 4'h8;
    resp_err_mode = 1'b1;
    exp_push(3, 32'h33, 1'b0);
    pulse(3, 32'h33);
    drain();
    checks++;
    if (bus_error !== 4'b1000) begin
      errors++;
      $display("FAIL bus_error_set got %b want 1000", bus_error);
    end
    resp_err_mode = 1'b0;
    exp_push(3, 32'h34, 1'b1);
    pulse(3, 32'h34);
    drain();
    exp_push(3, 32'h35, 1'b1);
    pulse(3, 32'h35);
    drain();
    checks++;
    if (bus_error !== 4'b1000) begin
      errors++;
      $display("FAIL bus_error_sticky got %b want 1000", bus_error);
    end
  endtask

  task automatic test_reset_in_wait();
    do_reset();
    enable = 4'h1;
    exp_push(0, 32'hC0, 1'b1);
    pulse(0, 32'hC0);
    drain();
    resp_hold = 1'b1;
    exp_push(0, 32'hC1, 1'b1);
    pulse(0, 32'hC1);
    wait_start();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || grant !== '0 || bus_if.master_start !== 1'b0) begin
      errors++;
      $display("FAIL reset_wait busy=%b grant=%b start=%b want 0", busy, grant, bus_if.master_start);
    end
    rst = 1'b0;
    for (int i = 0; i < NCH; i++) exp_ptr[i] = 0;
    @(negedge clk);
    man_done = 1'b1;
    @(negedge clk);
    man_done = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || wrap_cnt != 0) begin
      errors++;
      $display("FAIL late_done busy=%b wraps=%0d want 0/0", busy, wrap_cnt);
    end
    resp_hold = 1'b0;
    exp_push(0, 32'hC2, 1'b1);
    pulse(0, 32'hC2);
    drain();
  endtask

  initial begin
    base_addr = {32'h4000, 32'h3000, 32'h2000, 32'h1000};
    for (int i = 0; i < NCH; i++) exp_ptr[i] = 0;
    test_reset();
    test_round_robin();
    test_single();
    test_wrap();
    test_overrun();
    test_simultaneous();
    test_error();
    test_reset_in_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
